// File: rtl/mem_responder.sv
// Memory-side responder: answers held readM/writeM requests after LATENCY wait cycles
// from an internal word array, with a side-band preload port usable in any state.
module mem_responder #(
    parameter int WORD_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              readM,
    input  logic              writeM,
    input  logic [ADDR_W-1:0] address,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              inputReady,
    output logic              ackOutput,
    output logic              busy,
    output logic              err,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [WORD_W-1:0] load_data
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_RELEASE} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              op_wr, op_wr_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [WORD_W-1:0] wdata_lat, wdata_lat_nxt;
    logic [WORD_W-1:0] mem [DEPTH];

    logic              held;
    logic              rd_strobe_nxt, wr_strobe_nxt, err_nxt, busy_nxt;

    // Upper address bits alias onto the array; they are intentionally ignored.
    generate
        if (ADDR_W > IDX_W) begin : g_unused
            logic unused_hi;
            assign unused_hi = ^{address[ADDR_W-1:IDX_W], load_addr[ADDR_W-1:IDX_W]};
        end
    endgenerate

    assign held = op_wr ? writeM : readM;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            op_wr     <= 1'b0;
            idx       <= '0;
            wdata_lat <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            op_wr     <= op_wr_nxt;
            idx       <= idx_nxt;
            wdata_lat <= wdata_lat_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        op_wr_nxt     = op_wr;
        idx_nxt       = idx;
        wdata_lat_nxt = wdata_lat;
        case (state)
            S_IDLE: begin
                if (readM ^ writeM) begin
                    op_wr_nxt     = writeM;
                    idx_nxt       = address[IDX_W-1:0];
                    wdata_lat_nxt = wdata;
                    cnt_nxt       = CNT_W'(LATENCY);
                    state_nxt     = (LATENCY == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                // A dropped request line aborts before the wait completes.
                if (!held) begin
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1))
                        state_nxt = S_RESP;
                end
            end
            S_RESP:    state_nxt = S_RELEASE;
            S_RELEASE: if (!readM && !writeM) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rd_strobe_nxt = (state_nxt == S_RESP) && !op_wr_nxt;
        wr_strobe_nxt = (state_nxt == S_RESP) && op_wr_nxt;
        err_nxt       = (state == S_IDLE) && readM && writeM;
        busy_nxt      = (state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata      <= '0;
            inputReady <= 1'b0;
            ackOutput  <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            inputReady <= rd_strobe_nxt;
            ackOutput  <= wr_strobe_nxt;
            err        <= err_nxt;
            busy       <= busy_nxt;
            if (rd_strobe_nxt)
                rdata <= mem[idx_nxt];
        end
    end

    // Preload is written last so it overrides a same-edge response write to the same word.
    always_ff @(posedge clk) begin
        if (wr_strobe_nxt)
            mem[idx_nxt] <= wdata_lat_nxt;
        if (load_en)
            mem[load_addr[IDX_W-1:0]] <= load_data;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: LATENCY=2 and LATENCY=0 instances driven side by side,
// checked every cycle against a transaction-level model plus directed literal checks.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  rd = '0, wr = '0, ld = '0;
    logic [1:0]  ir, ack, busy, err;
    logic [15:0] addr [2];
    logic [15:0] wd   [2];
    logic [15:0] ldad [2];
    logic [15:0] ldda [2];
    logic [15:0] rdat [2];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_responder #(.WORD_W(16), .ADDR_W(16), .DEPTH(256), .LATENCY(2)) dut (
        .clk(clk), .reset_n(reset_n), .readM(rd[0]), .writeM(wr[0]), .address(addr[0]),
        .wdata(wd[0]), .rdata(rdat[0]), .inputReady(ir[0]), .ackOutput(ack[0]), .busy(busy[0]),
        .err(err[0]), .load_en(ld[0]), .load_addr(ldad[0]), .load_data(ldda[0]));

    mem_responder #(.WORD_W(16), .ADDR_W(16), .DEPTH(256), .LATENCY(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .readM(rd[1]), .writeM(wr[1]), .address(addr[1]),
        .wdata(wd[1]), .rdata(rdat[1]), .inputReady(ir[1]), .ackOutput(ack[1]), .busy(busy[1]),
        .err(err[1]), .load_en(ld[1]), .load_addr(ldad[1]), .load_data(ldda[1]));

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Transaction-level reference: a request is accepted when the responder is free,
    // answered LATENCY edges later unless its line drops, then held off until both lines drop.
    int          lats [2] = '{2, 0};
    logic [15:0] mm   [2][256];
    bit          pend [2] = '{0, 0};
    bit          inresp [2] = '{0, 0};
    bit          hold [2] = '{0, 0};
    bit          opw  [2] = '{0, 0};
    int          remn [2] = '{0, 0};
    logic [7:0]  ix   [2];
    logic [15:0] wl   [2];
    logic        e_ir [2] = '{0, 0};
    logic        e_ack [2] = '{0, 0};
    logic        e_err [2] = '{0, 0};
    logic        e_busy [2] = '{0, 0};
    logic [15:0] e_rd [2] = '{16'h0, 16'h0};

    always @(posedge clk or negedge reset_n) begin : mdl
        bit fire;
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                pend[i] = 0; inresp[i] = 0; hold[i] = 0;
                e_ir[i] = 0; e_ack[i] = 0; e_err[i] = 0; e_busy[i] = 0; e_rd[i] = '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                fire = 0;
                e_ir[i] = 0; e_ack[i] = 0; e_err[i] = 0;
                if (inresp[i]) begin
                    inresp[i] = 0; hold[i] = 1;
                end else if (hold[i]) begin
                    if (!rd[i] && !wr[i]) hold[i] = 0;
                end else if (pend[i]) begin
                    if (!(opw[i] ? wr[i] : rd[i])) pend[i] = 0;
                    else begin
                        remn[i]--;
                        if (remn[i] == 0) begin pend[i] = 0; fire = 1; end
                    end
                end else if (rd[i] && wr[i]) begin
                    e_err[i] = 1;
                end else if (rd[i] || wr[i]) begin
                    opw[i] = wr[i]; ix[i] = addr[i][7:0]; wl[i] = wd[i];
                    if (lats[i] == 0) fire = 1;
                    else begin pend[i] = 1; remn[i] = lats[i]; end
                end
                if (fire) begin
                    inresp[i] = 1;
                    if (opw[i]) begin mm[i][ix[i]] = wl[i]; e_ack[i] = 1; end
                    else begin e_rd[i] = mm[i][ix[i]]; e_ir[i] = 1; end
                end
                if (ld[i]) mm[i][ldad[i][7:0]] = ldda[i];
                e_busy[i] = pend[i] | inresp[i] | hold[i];
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d_inputReady", i), {15'b0, ir[i]},   {15'b0, e_ir[i]});
            chk($sformatf("u%0d_ackOutput", i),  {15'b0, ack[i]},  {15'b0, e_ack[i]});
            chk($sformatf("u%0d_err", i),        {15'b0, err[i]},  {15'b0, e_err[i]});
            chk($sformatf("u%0d_busy", i),       {15'b0, busy[i]}, {15'b0, e_busy[i]});
            chk($sformatf("u%0d_rdata", i),      rdat[i],          e_rd[i]);
        end
    end

    task automatic load(input int i, input logic [15:0] a, input logic [15:0] d);
        ld[i] = 1'b1; ldad[i] = a; ldda[i] = d;
        @(negedge clk);
        ld[i] = 1'b0;
    endtask

    // Holds a request for hold_n edges starting at the next edge, then watches three more cycles.
    task automatic txn(input int i, input logic r, input logic w, input logic [15:0] a,
                       input logic [15:0] d, input int hold_n, output int n_ir, output int n_ack,
                       output int n_err, output int first, output logic [15:0] rv,
                       output logic busy_drop);
        n_ir = 0; n_ack = 0; n_err = 0; first = -1; rv = '0; busy_drop = 1'b0;
        rd[i] = r; wr[i] = w; addr[i] = a; wd[i] = d;
        for (int c = 0; c < hold_n + 3; c++) begin
            @(negedge clk);
            if (ir[i] || ack[i] || err[i]) if (first < 0) first = c;
            if (ir[i]) begin n_ir++; rv = rdat[i]; end
            if (ack[i]) n_ack++;
            if (err[i]) n_err++;
            if (c == hold_n - 1) begin busy_drop = busy[i]; rd[i] = 1'b0; wr[i] = 1'b0; end
        end
    endtask

    initial begin
        int n_ir, n_ack, n_err, first;
        logic [15:0] rv;
        logic bd;
        for (int i = 0; i < 2; i++) begin
            addr[i] = '0; wd[i] = '0; ldad[i] = '0; ldda[i] = '0;
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int j = 0; j < 256; j++) begin
            @(negedge clk);
            ld = 2'b11;
            for (int i = 0; i < 2; i++) begin ldad[i] = 16'(j); ldda[i] = 16'($urandom); end
        end
        @(negedge clk);
        ld = 2'b00;

        // Read after preload, 2-cycle latency, busy held until readM drops.
        load(0, 16'h0010, 16'h1234);
        txn(0, 1, 0, 16'h0010, 16'h0, 4, n_ir, n_ack, n_err, first, rv, bd);
        chk("rd_count", 16'(n_ir), 16'd1);
        chk("rd_first", 16'(first), 16'd2);
        chk("rd_data", rv, 16'h1234);
        chk("rd_busy_held", {15'b0, bd}, 16'd1);
        chk("rd_busy_after", {15'b0, busy[0]}, 16'd0);

        // Write, read back, read through an aliased address.
        txn(0, 0, 1, 16'h0020, 16'hBEEF, 3, n_ir, n_ack, n_err, first, rv, bd);
        chk("wr_ack_count", 16'(n_ack), 16'd1);
        chk("wr_ack_first", 16'(first), 16'd2);
        chk("wr_no_ir", 16'(n_ir), 16'd0);
        txn(0, 1, 0, 16'h0020, 16'h0, 3, n_ir, n_ack, n_err, first, rv, bd);
        chk("wr_readback", rv, 16'hBEEF);
        txn(0, 1, 0, 16'h0120, 16'h0, 3, n_ir, n_ack, n_err, first, rv, bd);
        chk("alias_readback", rv, 16'hBEEF);

        // Illegal request: err pulse only, target untouched.
        load(0, 16'h0040, 16'h4040);
        txn(0, 1, 1, 16'h0040, 16'hDEAD, 1, n_ir, n_ack, n_err, first, rv, bd);
        chk("err_count", 16'(n_err), 16'd1);
        chk("err_first", 16'(first), 16'd0);
        chk("err_no_strobe", 16'(n_ir + n_ack), 16'd0);
        txn(0, 1, 0, 16'h0040, 16'h0, 3, n_ir, n_ack, n_err, first, rv, bd);
        chk("err_mem_kept", rv, 16'h4040);

        // Abort: writeM dropped during the wait.
        load(0, 16'h0050, 16'h5050);
        txn(0, 0, 1, 16'h0050, 16'hAAAA, 1, n_ir, n_ack, n_err, first, rv, bd);
        chk("abort_no_ack", 16'(n_ack), 16'd0);
        chk("abort_busy_drop", {15'b0, bd}, 16'd1);
        chk("abort_idle", {15'b0, busy[0]}, 16'd0);
        txn(0, 1, 0, 16'h0050, 16'h0, 3, n_ir, n_ack, n_err, first, rv, bd);
        chk("abort_mem_kept", rv, 16'h5050);

        // Asynchronous reset in the middle of a write.
        load(0, 16'h0030, 16'h0A0A);
        rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 16'h0030; wd[0] = 16'h5555;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_ir", {15'b0, ir[0]}, 16'd0);
        chk("rst_ack", {15'b0, ack[0]}, 16'd0);
        chk("rst_err", {15'b0, err[0]}, 16'd0);
        chk("rst_busy", {15'b0, busy[0]}, 16'd0);
        chk("rst_rdata", rdat[0], 16'h0);
        @(negedge clk);
        wr[0] = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_busy_after", {15'b0, busy[0]}, 16'd0);
        txn(0, 1, 0, 16'h0030, 16'h0, 3, n_ir, n_ack, n_err, first, rv, bd);
        chk("rst_write_dropped", rv, 16'h0A0A);
        txn(0, 1, 0, 16'h0010, 16'h0, 3, n_ir, n_ack, n_err, first, rv, bd);
        chk("rst_array_intact", rv, 16'h1234);

        // Zero-latency instance: one pulse despite readM held 3 extra cycles.
        load(1, 16'h0010, 16'h4321);
        txn(1, 1, 0, 16'h0010, 16'h0, 4, n_ir, n_ack, n_err, first, rv, bd);
        chk("l0_count", 16'(n_ir), 16'd1);
        chk("l0_first", 16'(first), 16'd0);
        chk("l0_data", rv, 16'h4321);
        txn(1, 0, 1, 16'h0077, 16'h7777, 2, n_ir, n_ack, n_err, first, rv, bd);
        chk("l0_ack_first", 16'(first), 16'd0);

        // Randomized traffic on both instances, small index range to force collisions.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                int pick;
                if ($urandom_range(0, 9) < 3) begin
                    pick = $urandom_range(0, 9);
                    rd[i] = (pick >= 4 && pick <= 6) || pick == 9;
                    wr[i] = (pick >= 7);
                end
                addr[i] = {8'($urandom), 4'h0, 4'($urandom)};
                wd[i]   = 16'($urandom);
                ld[i]   = ($urandom_range(0, 3) == 0);
                ldad[i] = {8'($urandom), 4'h0, 4'($urandom)};
                ldda[i] = 16'($urandom);
            end
        end
        @(negedge clk);
        rd = '0; wr = '0; ld = '0;
        repeat (6) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
